// File: rtl/program_loader.sv
// UART-fed IMEM loader: receives a length-prefixed little-endian image over 8N1
// serial and writes it word by word into the instruction memory write port.
module program_loader #(
  parameter int ENTRY        = 256,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     RXD,
  output logic                     WE,
  output logic [$clog2(ENTRY)-1:0] WADDR,
  output logic [31:0]              IDATA,
  output logic                     DONE,
  output logic                     ERR
);

  localparam int AW = $clog2(ENTRY);
  localparam int TW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_END = TW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;
  typedef enum logic [1:0] {LD_LEN, LD_DATA, LD_DONE, LD_FAIL} ldState_t;

  rxState_t       r_rxState;
  ldState_t       r_ldState;
  logic           r_rxMeta;
  logic           r_rxSync;
  logic [TW-1:0]  r_timer;
  logic [2:0]     r_bitCnt;
  logic [7:0]     r_shift;
  logic [1:0]     r_byteCnt;
  logic [31:0]    r_assemble;
  logic [AW:0]    r_len;
  logic [AW:0]    r_wordIdx;

  logic           w_byteVld;
  logic           w_frameErr;
  logic [31:0]    w_word;
  logic [AW:0]    w_nextIdx;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rxMeta <= 1'b1;
      r_rxSync <= 1'b1;
    end else begin
      r_rxMeta <= RXD;
      r_rxSync <= r_rxMeta;
    end
  end

  // Bytes complete on the stop-bit sample itself so the loader can register WE on that edge.
  assign w_byteVld  = (r_rxState == RX_STOP) && (r_timer == BIT_END) && r_rxSync;
  assign w_frameErr = (r_rxState == RX_STOP) && (r_timer == BIT_END) && !r_rxSync;
  assign w_word     = {r_shift, r_assemble[31:8]};
  assign w_nextIdx  = r_wordIdx + 1'b1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rxState <= RX_IDLE;
      r_timer   <= '0;
      r_bitCnt  <= '0;
      r_shift   <= '0;
    end else begin
      case (r_rxState)
        RX_IDLE: begin
          r_timer  <= '0;
          r_bitCnt <= '0;
          if (!r_rxSync) r_rxState <= RX_START;
        end
        RX_START: begin
          if (r_timer == HALF_END) begin
            r_timer   <= '0;
            r_rxState <= r_rxSync ? RX_IDLE : RX_DATA;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_timer == BIT_END) begin
            r_timer  <= '0;
            r_shift  <= {r_rxSync, r_shift[7:1]};
            r_bitCnt <= r_bitCnt + 1'b1;
            if (r_bitCnt == 3'd7) r_rxState <= RX_STOP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_timer == BIT_END) begin
            r_timer   <= '0;
            r_rxState <= RX_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: r_rxState <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ldState  <= LD_LEN;
      r_byteCnt  <= '0;
      r_assemble <= '0;
      r_len      <= '0;
      r_wordIdx  <= '0;
      WE         <= 1'b0;
      WADDR      <= '0;
      IDATA      <= '0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      WE <= 1'b0;
      if (w_frameErr) ERR <= 1'b1;
      case (r_ldState)
        LD_LEN: begin
          if (w_frameErr) begin
            r_ldState <= LD_FAIL;
          end else if (w_byteVld) begin
            r_byteCnt  <= r_byteCnt + 1'b1;
            r_assemble <= w_word;
            if (r_byteCnt == 2'd3) begin
              if (w_word == 32'd0) begin
                r_ldState <= LD_DONE;
                DONE      <= 1'b1;
              end else if (w_word > 32'(ENTRY)) begin
                r_ldState <= LD_FAIL;
                ERR       <= 1'b1;
              end else begin
                r_ldState <= LD_DATA;
                r_len     <= w_word[AW:0];
                r_wordIdx <= '0;
              end
            end
          end
        end
        LD_DATA: begin
          if (w_frameErr) begin
            r_ldState <= LD_FAIL;
          end else if (w_byteVld) begin
            r_byteCnt  <= r_byteCnt + 1'b1;
            r_assemble <= w_word;
            if (r_byteCnt == 2'd3) begin
              WE        <= 1'b1;
              WADDR     <= r_wordIdx[AW-1:0];
              IDATA     <= w_word;
              r_wordIdx <= w_nextIdx;
              if (w_nextIdx == r_len) begin
                r_ldState <= LD_DONE;
                DONE      <= 1'b1;
              end
            end
          end
        end
        LD_DONE: DONE <= 1'b1;
        LD_FAIL: DONE <= 1'b0;
        default: r_ldState <= LD_FAIL;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: serialises hand-built images onto RXD and
// checks the IMEM write strobes, DONE and ERR against hand-computed values.
module tb_program_loader;

  localparam int ENTRY = 64;
  localparam int CPB   = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        RXD = 1'b1;
  logic        WE;
  logic [5:0]  WADDR;
  logic [31:0] IDATA;
  logic        DONE;
  logic        ERR;

  int checks = 0;
  int failures = 0;

  logic [5:0]  weAddr [0:511];
  logic [31:0] weData [0:511];
  logic        weDone [0:511];
  int          weCnt = 0;
  int          widePulses = 0;
  logic        prevWe = 1'b0;

  program_loader #(.ENTRY(ENTRY), .CLKS_PER_BIT(CPB)) dut (
    .CLK(CLK), .RST(RST), .RXD(RXD), .WE(WE), .WADDR(WADDR),
    .IDATA(IDATA), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // Record every write strobe away from the active edge.
  always @(negedge CLK) begin
    if (WE) begin
      if (weCnt < 512) begin
        weAddr[weCnt] = WADDR;
        weData[weCnt] = IDATA;
        weDone[weCnt] = DONE;
      end
      weCnt = weCnt + 1;
      if (prevWe) widePulses = widePulses + 1;
    end
    prevWe = WE;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
    @(negedge CLK) RXD = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      repeat (CPB) @(negedge CLK);
    end
    RXD = stopBit;
    repeat (CPB) @(negedge CLK);
    RXD = 1'b1;
    repeat (CPB) @(negedge CLK);
  endtask

  task automatic sendWord(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] t;
      t = w >> (8 * i);
      applyStimulus(t[7:0], 1'b1);
    end
  endtask

  task automatic doReset();
    @(negedge CLK) RST = 1'b1;
    RXD = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_we"}, 32'(WE), 32'd0);
    checkOutput({tag, "_waddr"}, 32'(WADDR), 32'd0);
    checkOutput({tag, "_idata"}, IDATA, 32'd0);
    checkOutput({tag, "_done"}, 32'(DONE), 32'd0);
    checkOutput({tag, "_err"}, 32'(ERR), 32'd0);
  endtask

  int base;
  int orderErrs;
  logic [31:0] expWord;

  initial begin
    // Reset defaults and quiet line
    doReset();
    checkIdle("reset");
    base = weCnt;
    repeat (100) @(negedge CLK);
    checkOutput("idle_no_we", 32'(weCnt - base), 32'd0);

    // Single instruction
    doReset();
    base = weCnt;
    sendWord(32'd1);
    sendWord(32'h00D08193);
    repeat (10) @(negedge CLK);
    checkOutput("single_count", 32'(weCnt - base), 32'd1);
    checkOutput("single_addr", 32'(weAddr[base]), 32'd0);
    checkOutput("single_data", weData[base], 32'h00D08193);
    checkOutput("single_done_on_we", 32'(weDone[base]), 32'd1);
    checkOutput("single_done", 32'(DONE), 32'd1);
    checkOutput("single_err", 32'(ERR), 32'd0);

    // Multi-word image, then trailing bytes after DONE
    doReset();
    base = weCnt;
    widePulses = 0;
    sendWord(32'd3);
    sendWord(32'h11111111);
    sendWord(32'h22222222);
    sendWord(32'h33333333);
    repeat (10) @(negedge CLK);
    checkOutput("multi_count", 32'(weCnt - base), 32'd3);
    checkOutput("multi_addr0", 32'(weAddr[base]), 32'd0);
    checkOutput("multi_addr1", 32'(weAddr[base+1]), 32'd1);
    checkOutput("multi_addr2", 32'(weAddr[base+2]), 32'd2);
    checkOutput("multi_data0", weData[base], 32'h11111111);
    checkOutput("multi_data1", weData[base+1], 32'h22222222);
    checkOutput("multi_data2", weData[base+2], 32'h33333333);
    checkOutput("multi_done_early", 32'(weDone[base+1]), 32'd0);
    checkOutput("multi_done_last", 32'(weDone[base+2]), 32'd1);
    checkOutput("multi_pulse_width", 32'(widePulses), 32'd0);
    sendWord(32'hDEADBEEF);
    repeat (10) @(negedge CLK);
    checkOutput("multi_after_done", 32'(weCnt - base), 32'd3);
    checkOutput("multi_done_held", 32'(DONE), 32'd1);

    // N = 0
    doReset();
    base = weCnt;
    sendWord(32'd0);
    checkOutput("zero_done", 32'(DONE), 32'd1);
    checkOutput("zero_err", 32'(ERR), 32'd0);
    sendWord(32'hCAFEF00D);
    repeat (10) @(negedge CLK);
    checkOutput("zero_no_we", 32'(weCnt - base), 32'd0);

    // N = ENTRY fills the whole memory
    doReset();
    base = weCnt;
    sendWord(32'd64);
    for (int i = 0; i < 64; i++) sendWord({8'hA5, 8'(i), 8'(~i), 8'(i * 3)});
    repeat (10) @(negedge CLK);
    checkOutput("full_count", 32'(weCnt - base), 32'd64);
    orderErrs = 0;
    for (int i = 0; i < 64; i++) begin
      expWord = {8'hA5, 8'(i), 8'(~i), 8'(i * 3)};
      if (weAddr[base+i] !== 6'(i) || weData[base+i] !== expWord) orderErrs++;
    end
    checkOutput("full_order", 32'(orderErrs), 32'd0);
    checkOutput("full_last_addr", 32'(weAddr[base+63]), 32'd63);
    checkOutput("full_last_data", weData[base+63], 32'hA53FC0BD);
    checkOutput("full_done", 32'(DONE), 32'd1);
    checkOutput("full_err", 32'(ERR), 32'd0);

    // N = ENTRY+1 is rejected
    doReset();
    base = weCnt;
    sendWord(32'd65);
    checkOutput("over_err", 32'(ERR), 32'd1);
    sendWord(32'h12345678);
    repeat (10) @(negedge CLK);
    checkOutput("over_no_we", 32'(weCnt - base), 32'd0);
    checkOutput("over_done", 32'(DONE), 32'd0);

    // One-cycle glitch must not produce a byte
    doReset();
    base = weCnt;
    @(negedge CLK) RXD = 1'b0;
    @(negedge CLK) RXD = 1'b1;
    repeat (40) @(negedge CLK);
    sendWord(32'd1);
    sendWord(32'h0badf00d);
    repeat (10) @(negedge CLK);
    checkOutput("glitch_count", 32'(weCnt - base), 32'd1);
    checkOutput("glitch_data", weData[base], 32'h0badf00d);
    checkOutput("glitch_err", 32'(ERR), 32'd0);

    // Framing error inside a data word
    doReset();
    base = weCnt;
    sendWord(32'd1);
    applyStimulus(8'h93, 1'b1);
    applyStimulus(8'h81, 1'b0);
    repeat (10) @(negedge CLK);
    checkOutput("frame_err", 32'(ERR), 32'd1);
    applyStimulus(8'hD0, 1'b1);
    applyStimulus(8'h00, 1'b1);
    sendWord(32'h44444444);
    repeat (10) @(negedge CLK);
    checkOutput("frame_no_we", 32'(weCnt - base), 32'd0);
    checkOutput("frame_done", 32'(DONE), 32'd0);

    // Reset in the middle of an image, then a clean resend
    doReset();
    sendWord(32'd2);
    sendWord(32'hAAAA5555);
    applyStimulus(8'h01, 1'b1);
    applyStimulus(8'h02, 1'b1);
    @(negedge CLK) RST = 1'b1;
    @(negedge CLK) RST = 1'b0;
    checkIdle("midrst");
    base = weCnt;
    sendWord(32'd2);
    sendWord(32'h76543210);
    sendWord(32'hFEDCBA98);
    repeat (10) @(negedge CLK);
    checkOutput("resend_count", 32'(weCnt - base), 32'd2);
    checkOutput("resend_addr0", 32'(weAddr[base]), 32'd0);
    checkOutput("resend_addr1", 32'(weAddr[base+1]), 32'd1);
    checkOutput("resend_data0", weData[base], 32'h76543210);
    checkOutput("resend_data1", weData[base+1], 32'hFEDCBA98);
    checkOutput("resend_done", 32'(DONE), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
